// File: rtl/lm35_link_pkg.sv
// Shared definitions for the LM35 link receiver.
// Holds the frame geometry, the positions of the parity and marker bits,
// the receive FSM state type and the parity helper used by the frame checker.
package lm35_link_pkg;

  localparam int CHUNK_W      = 3;
  localparam int FRAME_CHUNKS = 4;
  localparam int FRAME_W      = 12;
  localparam int VALUE_W      = 10;
  localparam int CNT_W        = 3;

  localparam int   PARITY_POS = 1;
  localparam int   MARKER_POS = 0;
  localparam logic MARKER_VAL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } link_state_e;

  // Parity bit that makes the value plus parity carry an even number of ones.
  function automatic logic even_parity(input logic [VALUE_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/link_sync.sv
// Multi-flop synchroniser for asynchronous link inputs.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input bits
//   q        : synchronised level (EDGE=0) or one-cycle rise pulse (EDGE=1)
// Every instance with the same STAGES delays its input by the same number of
// cycles, so strobe and data chains stay aligned.
module link_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1,
  parameter bit EDGE   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Synchroniser shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic [WIDTH-1:0] prev_r;

      // Previous synchronised level, for rise detection.
      always_ff @(posedge clk) begin
        if (rst) begin
          prev_r <= {WIDTH{1'b0}};
        end else begin
          prev_r <= stage_r[STAGES-1];
        end
      end

      // Both operands are flops, so the pulse is glitch-free inside the domain.
      assign q = stage_r[STAGES-1] & ~prev_r;
    end else begin : g_level
      assign q = stage_r[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/lm35_link_rx.sv
// LM35 link receive stage.
// Assembles 4 x 3-bit strobed chunks into a 12-bit frame, checks marker,
// even parity and range, and publishes accepted temperatures.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   stb, frm, db  : asynchronous chunk strobe, frame-start flag, chunk data
//   data          : last accepted value (tenths of a degree), held
//   ack           : high once any frame has been accepted
//   upd           : one-cycle pulse when data is updated
//   err           : one-cycle pulse on a rejected or aborted frame
//   err_cnt       : saturating count of err pulses
module lm35_link_rx
  import lm35_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_VALUE      = 999,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stb,
  input  logic               frm,
  input  logic [CHUNK_W-1:0] db,
  output logic [VALUE_W-1:0] data,
  output logic               ack,
  output logic               upd,
  output logic               err,
  output logic [7:0]         err_cnt
);

  localparam int                 TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LAST_CHUNK = CNT_W'(FRAME_CHUNKS - 1);
  localparam logic [VALUE_W-1:0] MAX_V      = VALUE_W'(MAX_VALUE);

  logic               rise_s;
  logic [CHUNK_W:0]   fd_s;
  logic               frm_s;
  logic [CHUNK_W-1:0] db_s;

  link_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .EDGE(1'b1)) u_stb_sync (
    .clk (clk),
    .rst (rst),
    .d   (stb),
    .q   (rise_s)
  );

  link_sync #(.STAGES(SYNC_STAGES), .WIDTH(CHUNK_W + 1), .EDGE(1'b0)) u_fd_sync (
    .clk (clk),
    .rst (rst),
    .d   ({frm, db}),
    .q   (fd_s)
  );

  assign frm_s = fd_s[CHUNK_W];
  assign db_s  = fd_s[CHUNK_W-1:0];

  link_state_e        state_r, state_s;
  logic [FRAME_W-1:0] shift_r, shift_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [TMO_W-1:0]   tmo_r, tmo_s;
  logic [VALUE_W-1:0] data_s;
  logic               ack_s, upd_s, err_s;
  logic [7:0]         err_cnt_s;

  logic [VALUE_W-1:0] value_s;
  logic               frame_ok_s;

  assign value_s    = shift_r[FRAME_W-1 -: VALUE_W];
  assign frame_ok_s = (shift_r[MARKER_POS] == MARKER_VAL) &&
                      (shift_r[PARITY_POS] == even_parity(value_s)) &&
                      (value_s <= MAX_V);

  // Next-state, frame assembly, timeout and output decisions.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    tmo_s   = tmo_r;
    data_s  = data;
    ack_s   = ack;
    upd_s   = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Chunks without frm in IDLE are stray tails and are dropped silently.
        if (rise_s && frm_s) begin
          shift_s = {{(FRAME_W - CHUNK_W){1'b0}}, db_s};
          cnt_s   = CNT_W'(1);
          tmo_s   = {TMO_W{1'b0}};
          state_s = ST_RECV;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        // A strobe always beats a timeout landing in the same cycle.
        if (rise_s) begin
          tmo_s = {TMO_W{1'b0}};
          if (frm_s) begin
            err_s   = 1'b1;
            shift_s = {{(FRAME_W - CHUNK_W){1'b0}}, db_s};
            cnt_s   = CNT_W'(1);
            state_s = ST_RECV;
          end else begin
            shift_s = {shift_r[FRAME_W-CHUNK_W-1:0], db_s};
            cnt_s   = cnt_r + CNT_W'(1);
            if (cnt_r == LAST_CHUNK) begin
              state_s = ST_CHECK;
            end else begin
              state_s = ST_RECV;
            end
          end
        end else if (tmo_r == TMO_LAST) begin
          err_s   = 1'b1;
          tmo_s   = {TMO_W{1'b0}};
          state_s = ST_IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      ST_CHECK: begin
        // Any strobe seen here violates the link protocol and is dropped.
        state_s = ST_IDLE;
        if (frame_ok_s) begin
          data_s = value_s;
          ack_s  = 1'b1;
          upd_s  = 1'b1;
        end else begin
          err_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (err_s && (err_cnt != 8'hFF)) begin
      err_cnt_s = err_cnt + 8'd1;
    end else begin
      err_cnt_s = err_cnt;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      shift_r <= {FRAME_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      tmo_r   <= {TMO_W{1'b0}};
      data    <= {VALUE_W{1'b0}};
      ack     <= 1'b0;
      upd     <= 1'b0;
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
      tmo_r   <= tmo_s;
      data    <= data_s;
      ack     <= ack_s;
      upd     <= upd_s;
      err     <= err_s;
      err_cnt <= err_cnt_s;
    end
  end

endmodule

// File: tb/tb_lm35_link_rx.sv
// Self-checking bench for lm35_link_rx: event-level frame model plus
// directed literal checks and randomized frames.
module tb_lm35_link_rx;

  localparam int T = 50000;

  logic       clk = 1'b0;
  logic       rst, stb, frm;
  logic [2:0] db;
  logic [9:0] data;
  logic       ack, upd, err;
  logic [7:0] err_cnt;

  lm35_link_rx #(.TIMEOUT_CYCLES(T), .MAX_VALUE(999), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .stb     (stb),
    .frm     (frm),
    .db      (db),
    .data    (data),
    .ack     (ack),
    .upd     (upd),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected events keyed by the clock edge after which they are visible.
  bit  exp_upd [int];
  int  exp_val [int];
  bit  exp_err [int];

  // Frame assembly model state (owned by the stimulus process).
  bit          in_frame;
  int          acc_n;
  logic [11:0] acc;
  int          last_e;

  // Output model state (owned by the compare process).
  logic [9:0] m_data;
  bit         m_ack;
  int         m_cnt;

  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;
  int last_upd_cyc = -1, last_err_cyc = -1, n_upd = 0;
  int stb_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  // Frame-level reference: a chunk taken at edge e with flag f and data d.
  function automatic void model_chunk(input int e, input bit f, input logic [2:0] d);
    logic [9:0] v;
    bit         par_ok;
    if (in_frame && (e > last_e + T)) begin
      in_frame = 1'b0;                      // timeout already pending at last_e+T
    end else if (in_frame) begin
      exp_err.delete(last_e + T);           // strobe arrived in time
    end
    if (f) begin
      if (in_frame) exp_err[e] = 1'b1;      // restart mid-frame
      in_frame = 1'b1;
      acc      = {9'd0, d};
      acc_n    = 1;
    end else if (in_frame) begin
      acc   = {acc[8:0], d};
      acc_n = acc_n + 1;
    end
    if (in_frame && (acc_n == 4)) begin
      in_frame = 1'b0;
      v        = acc[11:2];
      par_ok   = (($countones(acc[11:1]) % 2) == 0);
      if (acc[0] && par_ok && (int'(v) <= 999)) begin
        exp_upd[e + 1] = 1'b1;
        exp_val[e + 1] = int'(v);
      end else begin
        exp_err[e + 1] = 1'b1;
      end
    end else if (in_frame) begin
      last_e           = e;
      exp_err[e + T]   = 1'b1;              // tentative timeout
    end
  endfunction

  function automatic logic [11:0] mk_frame(input int v, input bit bad_par, input bit bad_mark);
    logic [9:0] vv;
    vv = v[9:0];
    return {vv, 1'($countones(vv) % 2) ^ bad_par, ~bad_mark};
  endfunction

  task automatic send_chunk(input bit f, input logic [2:0] d, input int h, input int l);
    @(negedge clk);
    frm = f;
    db  = d;
    @(negedge clk);
    stb     = 1'b1;
    stb_cyc = cyc;
    model_chunk(cyc + 3, f, d);
    repeat (h) @(negedge clk);
    stb = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_frame(input logic [11:0] fr, input int nch);
    for (int i = 0; i < nch; i++) begin
      send_chunk(i == 0, fr[11 - 3*i -: 3], $urandom_range(1, 3), $urandom_range(1, 3));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 1'b0;
    rst    = 1'b1;
    stb    = 1'b0;
    frm    = 1'b0;
    db     = 3'd0;
    idle(3);
    exp_upd.delete();
    exp_val.delete();
    exp_err.delete();
    in_frame = 1'b0;
    m_data   = 10'd0;
    m_ack    = 1'b0;
    m_cnt    = 0;
    rst      = 1'b0;
    chk_en   = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_upd.exists(cyc)) begin
        m_data = exp_val[cyc][9:0];
        m_ack  = 1'b1;
      end
      if (exp_err.exists(cyc) && (m_cnt < 255)) m_cnt++;
      check("upd", 32'(upd), 32'(exp_upd.exists(cyc)));
      check("err", 32'(err), 32'(exp_err.exists(cyc)));
      check("data", 32'(data), 32'(m_data));
      check("ack", 32'(ack), 32'(m_ack));
      check("err_cnt", 32'(err_cnt), 32'(m_cnt));
      if (upd) begin
        last_upd_cyc = cyc;
        n_upd++;
      end
      if (err) last_err_cyc = cyc;
    end
  end

  initial begin
    int nu, sel, v, k;
    rst = 1'b1;
    stb = 1'b0;
    frm = 1'b0;
    db  = 3'd0;
    do_reset();
    idle(1);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Value 253, literal chunks.
    send_chunk(1'b1, 3'b001, 1, 1);
    send_chunk(1'b0, 3'b111, 2, 1);
    send_chunk(1'b0, 3'b110, 1, 2);
    send_chunk(1'b0, 3'b111, 1, 1);
    k = stb_cyc;
    idle(8);
    check("lat253", 32'(last_upd_cyc - k), 32'd4);
    check("data253", 32'(data), 32'd253);
    check("ack253", 32'(ack), 32'd1);
    check("cnt253", 32'(err_cnt), 32'd0);

    // Value 1000: range reject.
    nu = n_upd;
    send_chunk(1'b1, 3'b111, 1, 1);
    send_chunk(1'b0, 3'b110, 1, 1);
    send_chunk(1'b0, 3'b100, 1, 1);
    send_chunk(1'b0, 3'b001, 1, 1);
    k = stb_cyc;
    idle(8);
    check("range_errcyc", 32'(last_err_cyc - k), 32'd4);
    check("range_cnt", 32'(err_cnt), 32'd1);
    check("range_data", 32'(data), 32'd253);
    check("range_noupd", 32'(n_upd), 32'(nu));

    // Bad parity, then a good 253.
    send_chunk(1'b1, 3'b001, 1, 1);
    send_chunk(1'b0, 3'b111, 1, 1);
    send_chunk(1'b0, 3'b110, 1, 1);
    send_chunk(1'b0, 3'b101, 1, 1);
    idle(8);
    check("par_cnt", 32'(err_cnt), 32'd2);
    check("par_noupd", 32'(n_upd), 32'(nu));
    send_frame(mk_frame(253, 1'b0, 1'b0), 4);
    idle(8);
    check("par_recover_upd", 32'(n_upd), 32'(nu + 1));
    check("par_recover_data", 32'(data), 32'd253);

    // Timeout after two chunks.
    send_chunk(1'b1, 3'b001, 1, 1);
    send_chunk(1'b0, 3'b111, 1, 1);
    k = stb_cyc + 3;
    idle(T + 10);
    check("tmo_cyc", 32'(last_err_cyc - k), 32'(T));
    check("tmo_cnt", 32'(err_cnt), 32'd3);
    send_frame(mk_frame(500, 1'b0, 1'b0), 4);
    idle(8);
    check("tmo_next", 32'(data), 32'd500);

    // Restart mid-frame.
    send_frame(mk_frame(777, 1'b0, 1'b0), 2);
    send_frame(mk_frame(253, 1'b0, 1'b0), 4);
    idle(8);
    check("rs_cnt", 32'(err_cnt), 32'd4);
    check("rs_data", 32'(data), 32'd253);

    // Reset mid-frame; trailing chunks must be ignored.
    send_frame(mk_frame(253, 1'b0, 1'b0), 2);
    idle(5);
    do_reset();
    idle(1);
    check("rst2_data", 32'(data), 32'd0);
    check("rst2_ack", 32'(ack), 32'd0);
    check("rst2_cnt", 32'(err_cnt), 32'd0);
    nu = n_upd;
    send_chunk(1'b0, 3'b110, 1, 1);
    send_chunk(1'b0, 3'b111, 1, 1);
    idle(8);
    check("tail_noupd", 32'(n_upd), 32'(nu));
    check("tail_cnt", 32'(err_cnt), 32'd0);
    send_frame(mk_frame(253, 1'b0, 1'b0), 4);
    idle(8);
    check("post_rst_data", 32'(data), 32'd253);
    check("post_rst_ack", 32'(ack), 32'd1);

    // Randomized frames.
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 9);
      v   = $urandom_range(0, 1023);
      if (i % 17 == 0) v = 999;
      if (i % 19 == 0) v = 1000;
      if (sel == 9) send_chunk(1'b0, 3'($urandom_range(0, 7)), 1, 1);
      if (sel == 8) send_frame(mk_frame(v, 1'b0, 1'b0), $urandom_range(1, 3));
      else send_frame(mk_frame(v, sel == 6, sel == 7), 4);
      idle($urandom_range(0, 4));
    end
    idle(8);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) send_chunk(1'b1, 3'd0, 1, 1);
    for (int i = 0; i < 3; i++) send_chunk(1'b0, 3'd0, 1, 1);
    idle(8);
    check("sat_cnt", 32'(err_cnt), 32'd255);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lm35_link_rx.md
# lm35_link_rx

Upstream receive stage of the LM35 thermometer path. Takes the 3-bit-wide strobed link driven by the ESP32 and assembles 12-bit frames. Each frame is checked for marker, parity and range. Accepted frames yield a 10-bit temperature in tenths of °C (0–999) plus a level-valid flag, which the seven-segment display stage samples on its slow clock. Link inputs are asynchronous to `clk` and are synchronised here.

## Interface
- `TIMEOUT_CYCLES`, 50000, max `clk` cycles between chunk strobes inside a frame before abort (1 ms at 50 MHz)
- `MAX_VALUE`, 999, largest accepted value
- `SYNC_STAGES`, 2, synchroniser depth, applied identically to `stb`, `frm` and `db`

- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  reset, synchronous, active-high
- `stb`  in  1  async chunk strobe from ESP32; a chunk is taken on its rising edge
- `frm`  in  1  async frame-start flag; high while chunk 0 is presented
- `db`  in  3  async chunk data; stable from before `stb` rises until after it falls
- `data`  out  10  last accepted value, held between updates
- `ack`  out  1  level; high once any frame has been accepted, stays high until reset
- `upd`  out  1  one-cycle pulse when `data` is updated
- `err`  out  1  one-cycle pulse on any rejected or aborted frame
- `err_cnt`  out  8  saturating count of `err` pulses

## Operation
- Frame: 4 chunks × 3 bits, MSB first, giving bits [11:0].
  - [11:2] value
  - [1] even parity over value, so the total ones count in [11:1] is even
  - [0] marker, must be 1
- `stb_rise` is a one-cycle pulse derived from synchronised `stb`. Each `stb_rise` captures the synchronised `db` and `frm`.
- FSM states: IDLE, RECV, CHECK.
  - IDLE: on `stb_rise` with `frm`=1, load chunk into shift reg, chunk cnt=1, go to RECV. On `stb_rise` with `frm`=0, ignore the chunk (no err).
  - RECV, on `stb_rise` with `frm`=0: shift chunk in, cnt++. On cnt reaching 4, go to CHECK.
  - RECV, on `stb_rise` with `frm`=1: pulse `err`, reload as chunk 0, cnt=1, stay in RECV. Resync wins over abort.
  - RECV, timeout: the counter clears on every `stb_rise` and on entry. At `TIMEOUT_CYCLES` without a strobe, pulse `err` and go to IDLE. If a strobe and timeout land in the same cycle, the strobe wins.
  - CHECK: lasts exactly 1 cycle, then IDLE. Accept iff marker=1, parity ok and value ≤ `MAX_VALUE`.
    - Accept: `data`←value, `ack`←1, `upd` pulse.
    - Reject: `err` pulse, `data`/`ack` unchanged.
- `err_cnt` increments with each `err` pulse and saturates at 255.
- Reset values: `data`=0, `ack`=0, `upd`=0, `err`=0, `err_cnt`=0, FSM=IDLE, shift reg=0, timeout cnt=0, synchronisers=0.
- Reset mid-frame discards the partial frame. The first frame after reset must carry `frm`=1.

## Timing
- `stb` high at the input becomes `stb_rise` `SYNC_STAGES`+1 cycles later (3 by default).
- Final-chunk `stb_rise` at edge E leads to CHECK during cycle E→E+1. `data`/`upd`/`ack` are visible after edge E+1.
- End-to-end latency from final `stb` rise to `upd` is 4 cycles by default.
- `err` for parity, marker or range rejects appears after E+1. `err` for restart appears the cycle after the offending `stb_rise`.
- Throughput: a new frame may start in the cycle CHECK exits. A chunk 0 `stb_rise` during CHECK is not allowed by the link protocol. If it happens anyway, it is dropped.
- `upd` and `err` are never high in the same cycle.

## Structure
- Package `lm35_link_pkg` holds:
  - FSM state enum (IDLE, RECV, CHECK)
  - `CHUNK_W`=3, `FRAME_CHUNKS`=4, `FRAME_W`=12, `VALUE_W`=10
  - marker bit position and marker value
- Sub-module `link_sync`: `SYNC_STAGES` flop synchroniser with rise-detect output. Instantiated for `stb` (with edge) and as a vector for `frm`/`db`, so all three share the same depth and stay aligned.
- Top holds the FSM, shift reg, chunk counter, timeout counter, checker and output regs.

## Test plan
- Value 253: chunks 001,111,110,111 with `frm` on chunk 0 → `upd` 4 cycles after last `stb`, `data`=253, `ack`=1, `err`=0.
- Value 1000 (range reject): chunks 111,110,100,001 → `err` pulse, `err_cnt`=1, `data` keeps previous value, no `upd`.
- Bad parity: chunks 001,111,110,101 → `err` pulse, `data` unchanged. Then a good 253 frame → `data`=253.
- Timeout: 2 chunks then silence for `TIMEOUT_CYCLES` → `err` at exactly that count, FSM=IDLE. The next full frame is accepted.
- Restart: 2 chunks, then a new `frm`=1 frame for 253 → one `err`, then `data`=253 and `upd`.
- Reset: assert `rst` after chunk 2 → all outputs 0. Trailing chunks with `frm`=0 are ignored. The following full frame is accepted; 256 `err` events leave `err_cnt` at 255.
